// File: rtl/rr_arb_16_9b_if.sv
// Handshake and mux-control bundle between the round-robin scheduler and its environment.
// master is the scheduler side; slave is the requester, mux and downstream side.
interface rr_arb_16_9b_if;
  logic [15:0] req;
  logic [8:0]  res;
  logic        sel3;
  logic        sel2;
  logic        sel1;
  logic        sel0;
  logic [15:0] grant;
  logic [8:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  modport master (
    input  req, res, dout_ready,
    output sel3, sel2, sel1, sel0, grant, dout, dout_valid, busy
  );

  modport slave (
    output req, res, dout_ready,
    input  sel3, sel2, sel1, sel0, grant, dout, dout_valid, busy
  );
endinterface

// File: rtl/rr_arb_16_9b.sv
// Round-robin scheduler for a shared 16:1 9-bit mux: pick a requester, let the mux
// settle for one cycle, sample its result and offer it downstream over valid/ready.
module rr_arb_16_9b (
  input logic clk,
  input logic rst,
  rr_arb_16_9b_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, OFFER} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [3:0]  sel, sel_nxt;
  logic [15:0] grant, grant_nxt;
  logic [8:0]  dout, dout_nxt;
  logic        valid, valid_nxt;
  logic        busy, busy_nxt;
  logic        found;
  logic [3:0]  pick;
  logic [3:0]  cand;

  // Circular search upward from ptr; the 4-bit sum wraps 15 -> 0 on its own.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = '0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    grant_nxt = grant;
    dout_nxt  = dout;
    valid_nxt = valid;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nxt   = pick;
          grant_nxt = 16'b1 << pick;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        dout_nxt  = bus.res;
        valid_nxt = 1'b1;
        state_nxt = OFFER;
      end
      OFFER: begin
        if (bus.dout_ready) begin
          valid_nxt = 1'b0;
          grant_nxt = '0;
          ptr_nxt   = sel + 4'd1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        valid_nxt = 1'b0;
      end
    endcase
    // busy is registered alongside the state so it lines up with grant.
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      grant <= '0;
      dout  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      grant <= grant_nxt;
      dout  <= dout_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
    end
  end

  assign bus.sel3       = sel[3];
  assign bus.sel2       = sel[2];
  assign bus.sel1       = sel[1];
  assign bus.sel0       = sel[0];
  assign bus.grant      = grant;
  assign bus.dout       = dout;
  assign bus.dout_valid = valid;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_rr_arb_16_9b.sv
// Directed plus randomized bench for rr_arb_16_9b against a transaction-level
// round-robin model: expected winner, mux word and timing of each grant.
module tb_rr_arb_16_9b;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [8:0] muxData [16];
  int checks = 0;
  int failures = 0;
  int modelPtr = 0;
  int modelSel = 0;

  rr_arb_16_9b_if bus();

  assign bus.res = muxData[{bus.sel3, bus.sel2, bus.sel1, bus.sel0}];

  rr_arb_16_9b dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] selNow();
    return {bus.sel3, bus.sel2, bus.sel1, bus.sel0};
  endfunction

  // Winner is the first requester at or after the pointer, going around the ring.
  function automatic int pickNext(input logic [15:0] r, input int p);
    for (int i = 0; i < 16; i++) begin
      int k;
      k = (p + i) % 16;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.dout_valid), 32'd0);
    checkOutput({tag, "_sel"}, 32'(selNow()), 32'(modelSel));
  endtask

  // One full transaction from IDLE; hold = cycles of dout_ready low while offering.
  task automatic applyStimulus(input logic [15:0] r, input int hold, input bit dropReq);
    int idx;
    logic [8:0] expDout;
    idx = pickNext(r, modelPtr);
    bus.req = r;
    bus.dout_ready = (hold == 0);
    stepClk();
    if (idx < 0) begin
      checkIdle("noreq");
      return;
    end
    checkOutput("grant", 32'(bus.grant), 32'(1) << idx);
    checkOutput("sel", 32'(selNow()), 32'(idx));
    checkOutput("busy", 32'(bus.busy), 32'd1);
    checkOutput("valid_early", 32'(bus.dout_valid), 32'd0);
    expDout = muxData[idx];
    stepClk();
    checkOutput("dout", 32'(bus.dout), 32'(expDout));
    checkOutput("valid", 32'(bus.dout_valid), 32'd1);
    checkOutput("grant_settled", 32'(bus.grant), 32'(1) << idx);
    for (int c = 0; c < hold; c++) begin
      muxData[idx] = 9'($urandom);
      bus.req = 16'($urandom);
      if (dropReq) bus.req[idx] = 1'b0;
      stepClk();
      checkOutput("hold_dout", 32'(bus.dout), 32'(expDout));
      checkOutput("hold_sel", 32'(selNow()), 32'(idx));
      checkOutput("hold_grant", 32'(bus.grant), 32'(1) << idx);
      checkOutput("hold_valid", 32'(bus.dout_valid), 32'd1);
    end
    bus.dout_ready = 1'b1;
    stepClk();
    modelPtr = (idx + 1) % 16;
    modelSel = idx;
    checkIdle("done");
  endtask

  initial begin
    logic [15:0] r;
    bus.req = '0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) muxData[i] = 9'($urandom);

    #1 rst = 1'b1;
    #2;
    checkIdle("reset");
    checkOutput("reset_dout", 32'(bus.dout), 32'd0);
    stepClk();
    stepClk();
    rst = 1'b0;

    // Idle with no requests, then the basic single-requester transfer.
    bus.dout_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      stepClk();
      checkIdle("idle20");
    end
    muxData[0] = 9'h1A5;
    applyStimulus(16'h0001, 0, 1'b0);

    $display("[TB] full request ring");
    for (int n = 0; n < 17; n++) applyStimulus(16'hFFFF, 0, 1'b0);

    $display("[TB] pointer wrap");
    applyStimulus(16'h0001, 0, 1'b0);
    applyStimulus(16'h8001, 0, 1'b0);
    applyStimulus(16'h8001, 0, 1'b0);

    $display("[TB] stalled offer on index 5");
    applyStimulus(16'h0020, 10, 1'b1);
    applyStimulus(16'h0020, 0, 1'b0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 40; n++) begin
      r = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      applyStimulus(r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] asynchronous reset during offer");
    bus.req = 16'h0400;
    bus.dout_ready = 1'b0;
    stepClk();
    stepClk();
    checkOutput("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    modelPtr = 0;
    modelSel = 0;
    checkIdle("async_rst");
    checkOutput("async_rst_dout", 32'(bus.dout), 32'd0);
    #1 rst = 1'b0;
    applyStimulus(16'hFFFF, 0, 1'b0);
    applyStimulus(16'h0400, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
